// File: rtl/booth_mul_16.sv
// booth_mul_16: multi-cycle signed 16x16 -> 32-bit radix-2 Booth multiplier.
// Each iteration feeds the accumulator and +/-multiplicand through a single
// csa_16 carry-select adder. Bit 16 of the accumulator is computed alongside it.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   start    operation request, sampled only while not busy
//   a        multiplicand, signed two's complement
//   b        multiplier, signed two's complement
//   busy     high while iterating
//   done     one-cycle pulse, product valid
//   product  signed a*b, held until the next accepted start
//
// csa_16: 16-bit carry-select adder. The low byte ripples. The high byte is
// precomputed for both carry-in values and then selected.
//   a_i, b_i  addends; c_i carry in; sum_o sum; c_o carry out

module csa_16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        c_i,
    output logic [15:0] sum_o,
    output logic        c_o
);
    logic [8:0] lo_s;
    logic [8:0] hi0_s;
    logic [8:0] hi1_s;

    // Both high-half candidates plus the low half.
    always_comb begin
        lo_s  = {1'b0, a_i[7:0]} + {1'b0, b_i[7:0]} + {8'd0, c_i};
        hi0_s = {1'b0, a_i[15:8]} + {1'b0, b_i[15:8]};
        hi1_s = {1'b0, a_i[15:8]} + {1'b0, b_i[15:8]} + 9'd1;
    end

    // Select the high half by the low-half carry.
    always_comb begin
        if (lo_s[8]) begin
            sum_o = {hi1_s[7:0], lo_s[7:0]};
            c_o   = hi1_s[8];
        end else begin
            sum_o = {hi0_s[7:0], lo_s[7:0]};
            c_o   = hi0_s[8];
        end
    end
endmodule

module booth_mul_16 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               busy_q, done_q;

    logic               add_s, sub_s;
    logic [WIDTH-1:0]   csa_b_s, csa_sum_s;
    logic               csa_cout_s;
    logic               mx16_s;
    logic [WIDTH:0]     acc_op_s;
    logic [WIDTH:0]     acc_sh_s;
    logic [WIDTH-1:0]   q_sh_s;

    // Booth recoding of {Q[0], q_m1}; subtract uses ~M with carry-in 1.
    always_comb begin
        add_s   = ~q_q[0] & qm1_q;
        sub_s   = q_q[0] & ~qm1_q;
        csa_b_s = sub_s ? ~m_q : m_q;
        mx16_s  = sub_s ? ~m_q[WIDTH-1] : m_q[WIDTH-1];
    end

    csa_16 u_csa (
        .a_i   (acc_q[WIDTH-1:0]),
        .b_i   (csa_b_s),
        .c_i   (sub_s),
        .sum_o (csa_sum_s),
        .c_o   (csa_cout_s)
    );

    // 17-bit add result (bit 16 from sign bits and csa carry), then arithmetic shift.
    always_comb begin
        if (add_s | sub_s) begin
            acc_op_s = {acc_q[WIDTH] ^ mx16_s ^ csa_cout_s, csa_sum_s};
        end else begin
            acc_op_s = acc_q;
        end
        acc_sh_s = {acc_op_s[WIDTH], acc_op_s[WIDTH:1]};
        q_sh_s   = {acc_op_s[0], q_q[WIDTH-1:1]};
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    m_d     = a;
                    q_d     = b;
                    qm1_d   = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d = acc_sh_s;
                q_d   = q_sh_s;
                qm1_d = q_q[0];
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d   = ST_DONE;
                    product_d = {acc_sh_s[WIDTH-1:0], q_sh_s};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; busy/done registered from next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
endmodule

// File: tb/tb_booth_mul_16.sv
// Directed testbench for booth_mul_16. Inputs are driven and outputs are
// sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_booth_mul_16;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int checks = 0;
    int errors = 0;

    booth_mul_16 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    // Called at a falling edge: start for one cycle, return at the negedge after E0.
    task automatic issue(input logic [15:0] av, input logic [15:0] bv);
        start = 1'b1;
        a = av;
        b = bv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // From the negedge after E0: wait for done. Returns the product, the number of
    // busy samples, and the index n of the done sample (-1 on timeout).
    task automatic wait_done(output logic [31:0] p, output int busy_cnt, output int done_at);
        busy_cnt = 0;
        done_at = -1;
        p = 32'd0;
        for (int n = 0; n < 40; n++) begin
            if (n > 0) @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_at = n;
                p = product;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = 16'd0;
        b = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b product=%h, required 0 0 00000000", busy, done, product);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] p;
        int bc, da;
        issue(16'd3, 16'hFFFC);
        wait_done(p, bc, da);
        checks++;
        if (da !== 16) begin
            errors++;
            $display("FAIL basic_latency: done at %0d, required 16", da);
        end
        checks++;
        if (bc !== 16) begin
            errors++;
            $display("FAIL basic_busy: busy cycles %0d, required 16", bc);
        end
        checks++;
        if (p !== 32'hFFFF_FFF4) begin
            errors++;
            $display("FAIL basic_product: got %h, required FFFFFFF4", p);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_in_done: busy=%b, required 0", busy);
        end
        @(negedge clk);
    endtask

    task automatic test_corners();
        logic [15:0] av [3];
        logic [15:0] bv [3];
        logic [31:0] ev [3];
        logic [31:0] p;
        int bc, da;
        av[0] = 16'h8000; bv[0] = 16'h8000; ev[0] = 32'h4000_0000;
        av[1] = 16'h8000; bv[1] = 16'h7FFF; ev[1] = 32'hC000_8000;
        av[2] = 16'h0000; bv[2] = 16'hFFFF; ev[2] = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            issue(av[i], bv[i]);
            wait_done(p, bc, da);
            checks++;
            if (da !== 16 || p !== ev[i]) begin
                errors++;
                $display("FAIL corner%0d: done at %0d product %h, required 16 %h", i, da, p, ev[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_held();
        int done_cnt = 0;
        int first_done = -1;
        start = 1'b1;
        a = 16'd7;
        b = 16'd9;
        @(posedge clk);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 8) a = 16'd100;
            if (n == 15) start = 1'b0;
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = n;
            end
        end
        checks++;
        if (done_cnt !== 1 || first_done !== 16) begin
            errors++;
            $display("FAIL start_held_done: %0d pulses first at %0d, required 1 at 16", done_cnt, first_done);
        end
        checks++;
        if (product !== 32'd63) begin
            errors++;
            $display("FAIL start_held_product: got %h, required 0000003F", product);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] p;
        int bc, da;
        int held_bad = 0;
        issue(16'd6, 16'hFFF9);
        wait_done(p, bc, da);
        checks++;
        if (p !== 32'hFFFF_FFD6) begin
            errors++;
            $display("FAIL b2b_first: got %h, required FFFFFFD6", p);
        end
        // Still in the DONE cycle: request the next operation.
        issue(16'hFFFB, 16'd5);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_handoff: done=%b busy=%b, required 0 1", done, busy);
        end
        da = -1;
        for (int n = 0; n < 40; n++) begin
            if (n > 0) @(negedge clk);
            if (done) begin
                da = n;
                break;
            end
            if (product !== 32'hFFFF_FFD6) held_bad++;
        end
        checks++;
        if (held_bad !== 0) begin
            errors++;
            $display("FAIL b2b_held: %0d samples lost previous product, required 0", held_bad);
        end
        checks++;
        if (da !== 16 || product !== 32'hFFFF_FFE7) begin
            errors++;
            $display("FAIL b2b_second: done at %0d product %h, required 16 FFFFFFE7", da, product);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic [31:0] p;
        int bc, da;
        int done_cnt = 0;
        issue(16'd1234, 16'd567);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b product=%h, required 0 0 00000000", busy, done, product);
        end
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d pulses, required 0", done_cnt);
        end
        issue(16'd2, 16'd2);
        wait_done(p, bc, da);
        checks++;
        if (da !== 16 || p !== 32'd4) begin
            errors++;
            $display("FAIL abort_next: done at %0d product %h, required 16 00000004", da, p);
        end
        @(negedge clk);
    endtask

    task automatic test_sweep();
        logic [31:0] p;
        logic [15:0] av, bv;
        int bc, da;
        int exp_v;
        int sweep_err = 0;
        for (int i = 0; i < 512; i++) begin
            av = 16'(-32768 + 128 * i);
            bv = 16'(-32768 + 274 * i);
            exp_v = int'($signed(av)) * int'($signed(bv));
            issue(av, bv);
            wait_done(p, bc, da);
            checks++;
            if (da !== 16 || p !== 32'(exp_v)) begin
                errors++;
                sweep_err++;
                $display("FAIL sweep a=%0d b=%0d: done at %0d product %h, required 16 %h",
                         $signed(av), $signed(bv), da, p, 32'(exp_v));
            end
            @(negedge clk);
        end
        if (sweep_err == 0) $display("Sweep of 512 operand pairs: all products correct");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_start_held();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
